// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 device-to-host deframer with E0/F0 prefix stripping; define PARITY_CHECK_EN to enable odd-parity checking.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [8:0] scancode,
  output logic       pressed,
  output logic       Released,
  output logic       frame_err,
  output logic       parity_err
);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t        state_q, state_d;
  logic [1:0]    ck_q, dt_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [8:0]    code_q, code_d;
  logic          prs_q, prs_d, rel_q, rel_d, ferr_q, ferr_d;
  logic          flip, tick, din, timeout;
  assign din      = dt_q[1];
  assign flip     = (ck_q[1] != filt_q) && (fcnt_q == FW'(FILTER_LEN - 1));
  assign tick     = flip && filt_q;
  assign filt_d   = flip ? ~filt_q : filt_q;
  assign fcnt_d   = (ck_q[1] == filt_q || flip) ? '0 : fcnt_q + FW'(1);
  assign timeout  = (state_q != IDLE) && !tick && (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign scancode = code_q;
  assign pressed  = prs_q;
  assign Released = rel_q;
  assign frame_err = ferr_q;
`ifdef PARITY_CHECK_EN
  logic par_q, par_d, perr_q, perr_d;
  assign parity_err = perr_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
`else
  assign parity_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tmo_d   = (state_q == IDLE || tick) ? '0 : tmo_q + TW'(1);
    ext_d   = ext_q;
    brk_d   = brk_q;
    code_d  = code_q;
    prs_d   = 1'b0;
    rel_d   = 1'b0;
    ferr_d  = 1'b0;
`ifdef PARITY_CHECK_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    if (timeout) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end else if (tick) begin
      case (state_q)
        IDLE: if (!din) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
        DATA: begin
          sh_d    = {din, sh_q[7:1]};
          bit_d   = bit_q + 3'd1;
          state_d = (bit_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
`ifdef PARITY_CHECK_EN
          par_d = din;
`endif
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          if (!din) begin
            ferr_d = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end
`ifdef PARITY_CHECK_EN
          else if (^{sh_q, par_q} != 1'b1) begin
            perr_d = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end
`endif
          else if (sh_q == 8'hE0) ext_d = 1'b1;
          else if (sh_q == 8'hF0) brk_d = 1'b1;
          else begin
            code_d = {ext_q, sh_q};
            rel_d  = brk_q;
            prs_d  = !brk_q;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ck_q    <= 2'b11;
      dt_q    <= 2'b11;
      filt_q  <= 1'b1;
      fcnt_q  <= '0;
      state_q <= IDLE;
      bit_q   <= 3'd0;
      sh_q    <= 8'h00;
      tmo_q   <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      code_q  <= 9'h000;
      prs_q   <= 1'b0;
      rel_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      ck_q    <= {ck_q[0], ps2_clk};
      dt_q    <= {dt_q[0], ps2_data};
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
      state_q <= state_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tmo_q   <= tmo_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      code_q  <= code_d;
      prs_q   <= prs_d;
      rel_q   <= rel_d;
      ferr_q  <= ferr_d;
    end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: directed and random PS/2 frames checked against a keyboard-level model.
module tb_ps2_keyboard_rx;
  localparam int TMO = 400;
  localparam int H   = 20;
`ifdef PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [8:0] scancode;
  logic pressed, Released, frame_err, parity_err;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int n_prs = 0, n_rel = 0, n_ferr = 0, n_perr = 0, n_ovl = 0;
  logic m_ext = 1'b0, m_brk = 1'b0;
  logic [8:0] m_code = 9'h000;
  ps2_keyboard_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .scancode(scancode), .pressed(pressed), .Released(Released),
    .frame_err(frame_err), .parity_err(parity_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    n_prs  <= n_prs + int'(pressed);
    n_rel  <= n_rel + int'(Released);
    n_ferr <= n_ferr + int'(frame_err);
    n_perr <= n_perr + int'(parity_err);
    if (int'(pressed) + int'(Released) + int'(frame_err) + int'(parity_err) > 1) n_ovl <= n_ovl + 1;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask
  task automatic send(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_cyc(H);
      ps2_clk = 1'b0;
      wait_cyc(H);
      ps2_clk = 1'b1;
    end
    wait_cyc(H);
    ps2_data = 1'b1;
    wait_cyc(H);
  endtask
  task automatic frame(input string tag, input logic [7:0] b, input logic par, input logic stp);
    int p0, r0, f0, q0;
    int ep, er, ef, eq;
    p0 = n_prs; r0 = n_rel; f0 = n_ferr; q0 = n_perr;
    ep = 0; er = 0; ef = 0; eq = 0;
    send({stp, par, b, 1'b0}, 11);
    wait_cyc(2);
    if (!stp) begin
      ef = 1; m_ext = 1'b0; m_brk = 1'b0;
    end else if (PCHK && ((^b) ^ par) != 1'b1) begin
      eq = 1; m_ext = 1'b0; m_brk = 1'b0;
    end else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      m_code = {m_ext, b};
      if (m_brk) er = 1; else ep = 1;
      m_ext = 1'b0; m_brk = 1'b0;
    end
    check({tag, ".pressed"}, n_prs - p0, ep);
    check({tag, ".released"}, n_rel - r0, er);
    check({tag, ".frame_err"}, n_ferr - f0, ef);
    check({tag, ".parity_err"}, n_perr - q0, eq);
    check({tag, ".scancode"}, scancode, m_code);
  endtask
  function automatic logic odd(input logic [7:0] b);
    return ~^b;
  endfunction
  initial begin
    int f0, p0;
    logic [7:0] b;
    logic par, stp;
    wait_cyc(3);
    #1;
    check("reset.scancode", scancode, 9'h000);
    check("reset.strobes", {pressed, Released, frame_err, parity_err}, 4'h0);
    reset = 1'b1;
    wait_cyc(5);
    frame("make_5A", 8'h5A, 1'b1, 1'b1);
    frame("brk_F0", 8'hF0, odd(8'hF0), 1'b1);
    frame("brk_5A", 8'h5A, odd(8'h5A), 1'b1);
    frame("ext_E0", 8'hE0, odd(8'hE0), 1'b1);
    frame("ext_F0", 8'hF0, odd(8'hF0), 1'b1);
    frame("ext_75", 8'h75, odd(8'h75), 1'b1);
    frame("make_1C", 8'h1C, odd(8'h1C), 1'b1);
    frame("badpar_29", 8'h29, ~odd(8'h29), 1'b1);
    frame("good_29", 8'h29, odd(8'h29), 1'b1);
    frame("pre_E0", 8'hE0, odd(8'hE0), 1'b1);
    frame("badstop_33", 8'h33, odd(8'h33), 1'b0);
    frame("after_err_33", 8'h33, odd(8'h33), 1'b1);
    f0 = n_ferr; p0 = n_prs;
    frame("tmo_pre_E0", 8'hE0, odd(8'hE0), 1'b1);
    send(11'b000_0001_0110, 6);
    wait_cyc(TMO + 50);
    m_ext = 1'b0; m_brk = 1'b0;
    check("timeout.frame_err", n_ferr - f0, 1);
    check("timeout.pressed", n_prs - p0, 0);
    frame("tmo_after_1C", 8'h1C, odd(8'h1C), 1'b1);
    frame("rst_F0", 8'hF0, odd(8'hF0), 1'b1);
    send(11'b000_0000_1010, 4);
    reset = 1'b0;
    #1;
    m_ext = 1'b0; m_brk = 1'b0; m_code = 9'h000;
    check("midrst.scancode", scancode, 9'h000);
    check("midrst.strobes", {pressed, Released, frame_err, parity_err}, 4'h0);
    wait_cyc(4);
    reset = 1'b1;
    wait_cyc(5);
    frame("rst_after_5A", 8'h5A, odd(8'h5A), 1'b1);
    f0 = n_ferr + n_prs + n_rel + n_perr;
    ps2_data = 1'b0;
    wait_cyc(H);
    ps2_clk = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b1;
    wait_cyc(H);
    ps2_data = 1'b1;
    wait_cyc(H);
    check("glitch.strobes", n_ferr + n_prs + n_rel + n_perr - f0, 0);
    frame("glitch_after_1C", 8'h1C, odd(8'h1C), 1'b1);
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(3))
        0: b = 8'hE0;
        1: b = 8'hF0;
        default: b = 8'($urandom);
      endcase
      par = ($urandom_range(3) == 0) ? ~odd(b) : odd(b);
      stp = ($urandom_range(7) != 0);
      frame($sformatf("rand%0d_%02h", i, b), b, par, stp);
    end
    check("no_overlap", n_ovl, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
